// File: rtl/instr_loader.sv
// Boot loader: receives a word-count header and instruction words over a
// byte link, writes them to instruction memory and holds the CPU meanwhile.
module instr_loader #(
  parameter int inst_SIZE = 16,
  parameter int PC_SIZE   = 13
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_valid,
  input  logic [7:0]           rx_data,
  output logic                 rx_ready,
  input  logic                 reload,
  output logic                 imem_we,
  output logic [PC_SIZE-1:0]   imem_addr,
  output logic [inst_SIZE-1:0] imem_wdata,
  output logic                 cpu_hold,
  output logic                 done,
  output logic                 err
);

  typedef enum logic [2:0] {
    CNT_HI,
    CNT_LO,
    DATA_HI,
    DATA_LO,
    WRITE,
    DONE,
    ERR
  } state_t;

  localparam logic [16:0] CAP = 17'(1) << PC_SIZE;

  state_t           state;
  logic [15:0]      count;
  logic [PC_SIZE:0] wcnt;
  logic [15:0]      cnt_nxt;
  logic [PC_SIZE:0] wcnt_inc;

  assign cnt_nxt  = {count[15:8], rx_data};
  assign wcnt_inc = wcnt + {{PC_SIZE{1'b0}}, 1'b1};

  assign rx_ready = (state == CNT_HI) || (state == CNT_LO) ||
                    (state == DATA_HI) || (state == DATA_LO);
  assign imem_we  = (state == WRITE);
  assign cpu_hold = (state != DONE);
  assign done     = (state == DONE);
  assign err      = (state == ERR);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= CNT_HI;
      count      <= '0;
      wcnt       <= '0;
      imem_addr  <= '0;
      imem_wdata <= '0;
    end else begin
      unique case (state)
        CNT_HI: if (rx_valid) begin
          count <= {rx_data, 8'h00};
          state <= CNT_LO;
        end
        CNT_LO: if (rx_valid) begin
          count <= cnt_nxt;
          if (cnt_nxt == 16'h0000) begin
            state <= DONE;
          end else if ({1'b0, cnt_nxt} > CAP) begin
            state <= ERR;
          end else begin
            imem_addr <= '0;
            wcnt      <= '0;
            state     <= DATA_HI;
          end
        end
        DATA_HI: if (rx_valid) begin
          imem_wdata[15:8] <= rx_data;
          state            <= DATA_LO;
        end
        DATA_LO: if (rx_valid) begin
          imem_wdata[7:0] <= rx_data;
          state           <= WRITE;
        end
        WRITE: begin
          wcnt <= wcnt_inc;
          // wide counter ends the load, so a full memory never wraps the address
          if (16'(wcnt_inc) == count) begin
            state <= DONE;
          end else begin
            imem_addr <= imem_addr + {{(PC_SIZE-1){1'b0}}, 1'b1};
            state     <= DATA_HI;
          end
        end
        DONE, ERR: if (reload) begin
          count     <= '0;
          wcnt      <= '0;
          imem_addr <= '0;
          state     <= CNT_HI;
        end
        default: state <= CNT_HI;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_loader.sv
// Directed bench for instr_loader: byte-stream loads checked against
// hand-computed memory writes and status outputs.
module tb_instr_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        reload;
  logic        imem_we;
  logic [12:0] imem_addr;
  logic [15:0] imem_wdata;
  logic        cpu_hold;
  logic        done;
  logic        err;

  int checks = 0;
  int failures = 0;
  int rdy_bad = 0;
  logic [28:0] wq[$];

  instr_loader dut (
    .clk(clk), .rst(rst),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .reload(reload),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .cpu_hold(cpu_hold), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      wq.push_back({imem_addr, imem_wdata});
      if (rx_ready !== 1'b0) rdy_bad++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    int n = 0;
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    while (rx_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("send_timeout", 32'(n), 32'd0);
    @(posedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rx_valid = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst      = 1'b0;
    rx_valid = 1'b0;
    reload   = 1'b0;
    wq.delete();
    rdy_bad = 0;
  endtask

  task automatic wait_end(input string tag);
    int n = 0;
    @(negedge clk);
    rx_valid = 1'b0;
    while (done !== 1'b1 && err !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check(tag, 32'(n), 32'd0);
  endtask

  logic [15:0] gw[3];
  int bad;

  initial begin
    rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; reload = 1'b0;
    gw[0] = 16'h1111; gw[1] = 16'h2222; gw[2] = 16'hF00F;

    // reset state
    repeat (2) @(negedge clk);
    do_reset();
    check("rst_ready", 32'(rx_ready), 32'd1);
    check("rst_hold", 32'(cpu_hold), 32'd1);
    check("rst_flags", {30'd0, done, err}, 32'd0);
    check("rst_we", 32'(imem_we), 32'd0);
    check("rst_addr", 32'(imem_addr), 32'd0);
    check("rst_wdata", 32'(imem_wdata), 32'd0);

    // two words back to back
    send(8'h00); send(8'h02); send(8'h12); send(8'h34);
    send(8'hAB); send(8'hCD);
    @(negedge clk);
    rx_valid = 1'b0;
    check("t1_we2", 32'(imem_we), 32'd1);
    check("t1_hold_in_write", 32'(cpu_hold), 32'd1);
    @(negedge clk);
    check("t1_done", 32'(done), 32'd1);
    check("t1_hold", 32'(cpu_hold), 32'd0);
    check("t1_nwr", 32'(wq.size()), 32'd2);
    if (wq.size() == 2) begin
      check("t1_w0", 32'(wq[0]), 32'({13'd0, 16'h1234}));
      check("t1_w1", 32'(wq[1]), 32'({13'd1, 16'hABCD}));
    end
    check("t1_rdy_write", 32'(rdy_bad), 32'd0);

    // empty load
    do_reset();
    send(8'h00); send(8'h00);
    @(negedge clk);
    rx_valid = 1'b0;
    check("t2_done", 32'(done), 32'd1);
    check("t2_hold", 32'(cpu_hold), 32'd0);
    check("t2_nwr", 32'(wq.size()), 32'd0);

    // one past capacity -> error, then reload
    do_reset();
    send(8'h20); send(8'h01);
    @(negedge clk);
    rx_valid = 1'b0;
    check("t3_err", 32'(err), 32'd1);
    check("t3_hold", 32'(cpu_hold), 32'd1);
    check("t3_ready", 32'(rx_ready), 32'd0);
    check("t3_nwr", 32'(wq.size()), 32'd0);
    reload = 1'b1;
    @(negedge clk);
    reload = 1'b0;
    check("t3_reload_ready", 32'(rx_ready), 32'd1);
    check("t3_reload_err", 32'(err), 32'd0);
    send(8'h00); send(8'h01); send(8'hBE); send(8'hEF);
    wait_end("t3_timeout");
    check("t3_done", {30'd0, done, err}, 32'd2);
    check("t3_nwr2", 32'(wq.size()), 32'd1);
    if (wq.size() == 1)
      check("t3_w0", 32'(wq[0]), 32'({13'd0, 16'hBEEF}));

    // gapped stream; a reload pulse mid-load must be ignored
    do_reset();
    send(8'h00);
    @(negedge clk);
    rx_valid = 1'b0;
    reload   = 1'b1;
    @(negedge clk);
    reload = 1'b0;
    send(8'h03);
    for (int i = 0; i < 3; i++) begin
      idle($urandom_range(0, 3));
      send(gw[i][15:8]);
      idle($urandom_range(0, 3));
      send(gw[i][7:0]);
    end
    wait_end("t4_timeout");
    check("t4_done", 32'(done), 32'd1);
    check("t4_nwr", 32'(wq.size()), 32'd3);
    bad = 0;
    for (int i = 0; i < 3; i++)
      if (i < wq.size() && wq[i] !== {13'(i), gw[i]}) bad++;
    check("t4_words", 32'(bad), 32'd0);
    check("t4_rdy_write", 32'(rdy_bad), 32'd0);

    // reset mid-load, with valid and reload also high
    do_reset();
    send(8'h00); send(8'h04); send(8'hDE); send(8'hAD); send(8'h55);
    @(negedge clk);
    rst    = 1'b1;
    reload = 1'b1;
    rx_data = 8'h77;
    @(negedge clk);
    rst      = 1'b0;
    reload   = 1'b0;
    rx_valid = 1'b0;
    check("t5_addr", 32'(imem_addr), 32'd0);
    check("t5_wdata", 32'(imem_wdata), 32'd0);
    check("t5_flags", {29'd0, cpu_hold, done, err}, 32'd4);
    check("t5_ready", 32'(rx_ready), 32'd1);
    repeat (5) @(negedge clk);
    check("t5_we", 32'(imem_we), 32'd0);
    check("t5_nwr", 32'(wq.size()), 32'd1);
    if (wq.size() == 1)
      check("t5_w0", 32'(wq[0]), 32'({13'd0, 16'hDEAD}));

    // full memory
    do_reset();
    send(8'h20); send(8'h00);
    for (int i = 0; i < 8192; i++) begin
      send(8'(i >> 5) ^ 8'hA5);
      send(8'(i));
    end
    wait_end("t6_timeout");
    check("t6_done", {30'd0, done, err}, 32'd2);
    check("t6_nwr", 32'(wq.size()), 32'd8192);
    bad = 0;
    for (int i = 0; i < wq.size() && i < 8192; i++)
      if (wq[i] !== {13'(i), 8'(i >> 5) ^ 8'hA5, 8'(i)}) bad++;
    check("t6_words", 32'(bad), 32'd0);
    if (wq.size() > 0)
      check("t6_last_addr", 32'(wq[wq.size()-1][28:16]), 32'd8191);
    repeat (3) @(negedge clk);
    check("t6_no_extra", 32'(wq.size()), 32'd8192);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
